// File: rtl/display_button_scanner_if.sv
// Avalon-MM slave bundle for the button scanner: register read port plus the
// press interrupt.
interface display_button_scanner_if;
   logic        avs_address;
   logic        avs_read;
   logic [31:0] avs_readdata;
   logic        irq;

   modport master (output avs_address, output avs_read,
                   input  avs_readdata, input irq);
   modport slave  (input  avs_address, input avs_read,
                   output avs_readdata, output irq);
endinterface

// File: rtl/display_button_scanner.sv
// Periodic PISO button-chain reader: load, shift, two-scan debounce, and a
// sticky press-flag register with IRQ behind an Avalon-MM slave.
module display_button_scanner #(
   parameter int NUM_BITS    = 16,
   parameter int CLK_DIV     = 25,
   parameter int SCAN_PERIOD = 500000,
   parameter int ACTIVE_LOW  = 1
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   output logic                     o_shift_load,
   output logic                     o_shift_clkin,
   input  logic                     i_shift_out,
   display_button_scanner_if.slave  avs
);
   localparam int CW = $clog2(SCAN_PERIOD);
   localparam int DW = $clog2(CLK_DIV + 1);
   localparam int IW = $clog2(NUM_BITS);
   localparam logic [CW-1:0]       CNT_MAX  = CW'(SCAN_PERIOD - 1);
   localparam logic [DW-1:0]       DIV_MAX  = DW'(CLK_DIV - 1);
   localparam logic [IW-1:0]       IDX_MAX  = IW'(NUM_BITS - 1);
   localparam logic [NUM_BITS-1:0] INV_MASK = {NUM_BITS{(ACTIVE_LOW != 0)}};

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETTLE, S_SHIFT, S_UPDATE} state_t;

   state_t              r_state;
   logic [CW-1:0]       r_cnt;
   logic [DW-1:0]       r_div;
   logic                r_ph;
   logic [IW-1:0]       r_idx;
   logic [1:0]          r_sync;
   logic [NUM_BITS-1:0] r_shreg, r_prev, r_buttons, r_pressed;
   logic [31:0]         r_readdata;
   logic                r_irq, r_shift_load, r_shift_clkin;

   logic                w_tick, w_rd_clr;
   logic [NUM_BITS-1:0] w_s, w_buttons_nxt, w_rise;
   logic [31:0]         w_rdata;

   assign w_tick        = (r_state != S_IDLE) && (r_div == DIV_MAX);
   assign w_s           = r_shreg ^ INV_MASK;
   assign w_buttons_nxt = (r_state == S_UPDATE && w_s == r_prev) ? w_s : r_buttons;
   assign w_rise        = w_buttons_nxt & ~r_buttons;
   assign w_rd_clr      = avs.avs_read && avs.avs_address;

   always_comb begin
      w_rdata = '0;
      if (avs.avs_address) w_rdata[NUM_BITS-1:0] = r_pressed;
      else                 w_rdata[NUM_BITS-1:0] = r_buttons;
   end

   // The scan counter free-runs so scan starts stay exactly SCAN_PERIOD apart.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state       <= S_IDLE;
         r_cnt         <= '0;
         r_div         <= '0;
         r_ph          <= 1'b0;
         r_idx         <= '0;
         r_sync        <= '0;
         r_shreg       <= '0;
         r_prev        <= '0;
         r_buttons     <= '0;
         r_shift_load  <= 1'b1;
         r_shift_clkin <= 1'b0;
      end else begin
         r_sync    <= {r_sync[0], i_shift_out};
         r_cnt     <= (r_cnt == CNT_MAX) ? '0 : r_cnt + CW'(1);
         r_div     <= (r_state == S_IDLE || w_tick) ? '0 : r_div + DW'(1);
         r_buttons <= w_buttons_nxt;
         case (r_state)
            S_IDLE: if (r_cnt == CNT_MAX) begin
               r_state      <= S_LOAD;
               r_shift_load <= 1'b0;
               r_ph         <= 1'b0;
            end
            S_LOAD: if (w_tick) begin
               r_ph <= ~r_ph;
               if (r_ph) begin
                  r_state      <= S_SETTLE;
                  r_shift_load <= 1'b1;
               end
            end
            S_SETTLE: if (w_tick) begin
               r_state <= S_SHIFT;
               r_idx   <= IDX_MAX;
               r_ph    <= 1'b0;
            end
            // Sample before raising the clock so the chain's MSB is read first.
            S_SHIFT: if (w_tick) begin
               r_ph <= ~r_ph;
               if (!r_ph) begin
                  r_shreg[r_idx] <= r_sync[1];
                  r_shift_clkin  <= 1'b1;
               end else begin
                  r_shift_clkin <= 1'b0;
                  if (r_idx == '0) r_state <= S_UPDATE;
                  else             r_idx   <= r_idx - IW'(1);
               end
            end
            S_UPDATE: begin
               r_prev  <= w_s;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // A new press in the same cycle as a clearing read survives the clear.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_pressed  <= '0;
         r_readdata <= '0;
         r_irq      <= 1'b0;
      end else begin
         r_pressed <= w_rise | (w_rd_clr ? '0 : r_pressed);
         if (avs.avs_read) r_readdata <= w_rdata;
         r_irq <= |r_pressed;
      end
   end

   assign o_shift_load     = r_shift_load;
   assign o_shift_clkin    = r_shift_clkin;
   assign avs.avs_readdata = r_readdata;
   assign avs.irq          = r_irq;
endmodule

// File: tb/tb_display_button_scanner.sv
// Directed bench for display_button_scanner with a behavioural PISO chain
// model on the SHIFT_* pins.
module tb_display_button_scanner;
   logic clk = 1'b0;
   logic reset;
   logic shift_load, shift_clkin, shift_out;
   logic [15:0] chain = 16'hFFFF;
   logic [15:0] pat;
   logic clkin_q = 1'b0;
   int n_assert = 0;
   int n_fail = 0;

   display_button_scanner_if bus();

   display_button_scanner #(.NUM_BITS(16), .CLK_DIV(2), .SCAN_PERIOD(200), .ACTIVE_LOW(1)) dut (
      .i_clk(clk), .i_reset(reset), .o_shift_load(shift_load),
      .o_shift_clkin(shift_clkin), .i_shift_out(shift_out), .avs(bus));

   always #5 clk = ~clk;

   // Chain: parallel load while load is low, shift toward the MSB on clkin rise.
   always @(posedge clk) begin
      clkin_q <= shift_clkin;
      if (!shift_load) chain <= pat;
      else if (shift_clkin && !clkin_q) chain <= {chain[14:0], 1'b1};
   end
   assign shift_out = chain[15];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic rd(input logic a, input logic [31:0] exp, input string tag);
      bus.avs_address = a;
      bus.avs_read = 1'b1;
      @(negedge clk);
      bus.avs_read = 1'b0;
      chk(tag, bus.avs_readdata, exp);
   endtask

   task automatic wait_fall();
      int n = 0;
      while (shift_load !== 1'b0 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 1000) chk("load_fall_timeout", {31'd0, shift_load}, 32'd0);
   endtask

   // Returns in the cycle after UPDATE; with rd_upd an addr-1 read hits UPDATE.
   task automatic scan(input logic [15:0] p, input bit rd_upd);
      pat = p;
      wait_fall();
      if (rd_upd) begin
         repeat (70) @(negedge clk);
         bus.avs_address = 1'b1;
         bus.avs_read = 1'b1;
         @(negedge clk);
         bus.avs_read = 1'b0;
      end else begin
         repeat (71) @(negedge clk);
      end
   endtask

   initial begin
      int k, lo, rises;
      logic prev_ck;
      reset = 1'b1;
      pat = 16'hFFFF;
      bus.avs_address = 1'b0;
      bus.avs_read = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_load", {31'd0, shift_load}, 32'd1);
      chk("rst_clkin", {31'd0, shift_clkin}, 32'd0);
      chk("rst_irq", {31'd0, bus.irq}, 32'd0);
      chk("rst_rdata", bus.avs_readdata, 32'd0);
      reset = 1'b0;

      // Idle length, LOAD width, clock count
      k = 0;
      while (shift_load === 1'b1 && k < 1000) begin
         @(negedge clk);
         k++;
      end
      chk("first_scan_delay", k, 200);
      lo = 1;
      while (shift_load === 1'b0 && lo < 100) begin
         @(negedge clk);
         if (shift_load === 1'b0) lo++;
      end
      chk("load_low_cycles", lo, 4);
      rises = 0;
      prev_ck = shift_clkin;
      repeat (70) begin
         @(negedge clk);
         if (shift_clkin && !prev_ck) rises++;
         prev_ck = shift_clkin;
      end
      chk("clk_rises", rises, 16);
      rd(1'b0, 32'd0, "idle_buttons");

      // Bounce never debounces
      scan(16'hFFFE, 0); rd(1'b0, 32'd0, "bounce1");
      scan(16'hFFFF, 0); rd(1'b0, 32'd0, "bounce2");
      scan(16'hFFFE, 0); rd(1'b0, 32'd0, "bounce3");
      scan(16'hFFFF, 0); rd(1'b0, 32'd0, "bounce4");
      chk("bounce_irq", {31'd0, bus.irq}, 32'd0);

      // Two matching scans
      scan(16'hFFFE, 0); rd(1'b0, 32'd0, "deb_first");
      scan(16'hFFFE, 0);
      chk("irq_lag", {31'd0, bus.irq}, 32'd0);
      rd(1'b0, 32'd1, "deb_second");
      chk("irq_rise", {31'd0, bus.irq}, 32'd1);

      // Clearing read in the cycle bit 3 sets
      scan(16'hFFF6, 0); rd(1'b0, 32'd1, "race_hold");
      scan(16'hFFF6, 1);
      chk("race_rdata", bus.avs_readdata, 32'd1);
      chk("race_irq0", {31'd0, bus.irq}, 32'd1);
      @(negedge clk);
      chk("race_irq1", {31'd0, bus.irq}, 32'd1);
      rd(1'b0, 32'd9, "race_buttons");
      rd(1'b1, 32'd8, "race_pressed");
      chk("clr_irq_lag", {31'd0, bus.irq}, 32'd1);
      @(negedge clk);
      chk("clr_irq_drop", {31'd0, bus.irq}, 32'd0);

      // Release keeps the sticky flag
      scan(16'hFFFF, 0); scan(16'hFFFF, 0);
      rd(1'b0, 32'd0, "rel_pre");
      scan(16'hFFFE, 0); scan(16'hFFFE, 0);
      @(negedge clk);
      chk("rel_irq_set", {31'd0, bus.irq}, 32'd1);
      scan(16'hFFFF, 0); scan(16'hFFFF, 0);
      rd(1'b0, 32'd0, "rel_buttons");
      chk("rel_irq_held", {31'd0, bus.irq}, 32'd1);
      rd(1'b1, 32'd1, "rel_pressed");
      chk("rel_irq_lag", {31'd0, bus.irq}, 32'd1);
      @(negedge clk);
      chk("rel_irq_drop", {31'd0, bus.irq}, 32'd0);
      rd(1'b1, 32'd0, "rel_cleared");

      // Reset during bit index 7
      scan(16'hFFF7, 0); scan(16'hFFF7, 0);
      rd(1'b0, 32'd8, "pre_rst_buttons");
      pat = 16'hFFFE;
      wait_fall();
      repeat (39) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_load", {31'd0, shift_load}, 32'd1);
      chk("mid_rst_clkin", {31'd0, shift_clkin}, 32'd0);
      chk("mid_rst_irq", {31'd0, bus.irq}, 32'd0);
      chk("mid_rst_rdata", bus.avs_readdata, 32'd0);
      reset = 1'b0;
      pat = 16'hFFF7;
      rd(1'b0, 32'd0, "mid_rst_buttons");
      rd(1'b1, 32'd0, "mid_rst_pressed");
      k = 2;
      while (shift_load === 1'b1 && k < 1000) begin
         @(negedge clk);
         k++;
      end
      chk("rst_scan_delay", k, 200);
      repeat (71) @(negedge clk);
      rd(1'b0, 32'd0, "post_rst_first");
      scan(16'hFFF7, 0);
      rd(1'b0, 32'd8, "post_rst_second");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/display_button_scanner.md
Name: display_button_scanner

Overview:
- Reader for the display-board button shift register: a parallel-in/serial-out chain driven by SHIFT_LOAD and SHIFT_CLKIN, with serial data returned on SHIFT_OUT.
- Periodically loads and shifts in the button states, debounces them across two scans and inverts them to active-high.
- Exposes the result to the HPS over an Avalon-MM slave: a current-state register and a sticky press-flag register that raises an IRQ.
- Instantiated inside the Qsys system alongside the pixel stream block; its conduit connects to the SHIFT_* pins.

Parameters:
NUM_BITS, 16, length of the shift chain; number of buttons sampled per scan (2..32)
CLK_DIV, 25, clk cycles per shift-clock half-period (25 gives 1 MHz at 50 MHz)
SCAN_PERIOD, 500000, clk cycles between scan starts (10 ms at 50 MHz); must exceed the scan length
ACTIVE_LOW, 1, 1 means the chain reads 0 for a pressed button, so samples are inverted

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high
shift_load  output  1  to SHIFT_LOAD; low loads the chain in parallel
shift_clkin  output  1  to SHIFT_CLKIN; data advances on the rising edge
shift_out  input  1  from SHIFT_OUT; serial data, first bit is the chain MSB
avs_address  input  1  0 = BUTTONS, 1 = PRESSED
avs_read  input  1  read strobe
avs_readdata  output  32  read data, registered, fixed latency 1
irq  output  1  high while any PRESSED bit is set

Behaviour:
- Reset values:
  - shift_load=1, shift_clkin=0, avs_readdata=0, irq=0.
  - BUTTONS=0, PRESSED=0, previous-sample register=0.
  - State=IDLE, scan counter=0, divider=0.
- Tick: an internal strobe asserted for one cycle every CLK_DIV cycles; the divider runs only outside IDLE and restarts at 0 on entry to LOAD.
- shift_out is passed through a 2-flop synchroniser before sampling.
- IDLE:
  - Scan counter increments each cycle.
  - At SCAN_PERIOD-1: counter returns to 0, state goes to LOAD.
  - The first scan after reset starts SCAN_PERIOD cycles after reset deasserts.
- LOAD: shift_load=0, shift_clkin=0 for 2 ticks, then go to SETTLE.
- SETTLE: shift_load=1 for 1 tick, then go to SHIFT with bit index=NUM_BITS-1.
- SHIFT, each bit takes 2 ticks:
  - First tick: sample shreg[index] <= synchronised shift_out, then drive shift_clkin=1.
  - Second tick: drive shift_clkin=0 and decrement the index.
  - After the index-0 bit completes, go to UPDATE.
  - Exactly NUM_BITS rising edges occur; the final one is harmless.
- UPDATE, one cycle, then back to IDLE:
  - s = shreg XOR {NUM_BITS{ACTIVE_LOW}}.
  - If s == prev: BUTTONS <= s. Otherwise BUTTONS is held.
  - prev <= s in both cases.
  - Debounce therefore needs 2 consecutive identical scans.
- Press flags:
  - PRESSED[i] is set in the cycle BUTTONS[i] goes 0→1.
  - Release does not clear it.
- Register reads:
  - A read of address 1 clears all PRESSED bits that were set at the read cycle.
  - If a bit sets in the same cycle as the clearing read, the set wins and the bit stays 1.
  - Reads of address 0 have no side effect.
  - avs_readdata is valid in the cycle after avs_read, zero-extended above NUM_BITS.
  - When avs_read=0, avs_readdata holds its last value.
- irq = |PRESSED, registered, 1-cycle lag behind PRESSED.
- Scan timing: one scan occupies (3 + 2·NUM_BITS)·CLK_DIV + 1 cycles.
- Reset mid-scan: all outputs return to reset values in the next cycle, shift_load goes high immediately and the partial scan is discarded.
- shift_out changes between samples are ignored; only tick-aligned samples matter.

Test Plan:
1. Reset, then idle (CLK_DIV=2, NUM_BITS=16, SCAN_PERIOD=200) → shift_load=1, shift_clkin=0, irq=0. First shift_load fall occurs 200 cycles after reset release and stays low exactly 4 cycles. Exactly 16 shift_clkin rising edges follow per scan.
2. Chain model presents 16'hFFFE (button 0 pressed, active-low) for two scans → after the first scan, read addr 0 gives 0. After the second, it gives 32'h0000_0001, PRESSED=1 and irq rises 1 cycle after PRESSED.
3. Bounce: model alternates 16'hFFFE / 16'hFFFF on successive scans → BUTTONS stays 0 and irq stays 0.
4. Read-clear race: read addr 1 in the same cycle that BUTTONS bit 3 rises, with bit 0 already set → readdata=32'h1. Bit 0 clears, bit 3 remains, irq stays 1.
5. Release: button 0 held for 2 scans, then released for 2 scans → BUTTONS returns to 0, PRESSED bit 0 still 1 until an addr-1 read. That read returns 32'h1 and irq drops 1 cycle after the clear.
6. Reset asserted during the SHIFT state at bit index 7 → the next cycle shows shift_load=1, shift_clkin=0, BUTTONS=0. The next scan starts SCAN_PERIOD cycles after release, with no partial data applied.
